// File: rtl/hit_record_join_if.sv
// hit_record_join_if: stream bundle around the hit record join block.
// Upstream hit-point stream (with its sideband flags), upstream normal
// stream, and the downstream joined-record stream. The slave modport is the
// join block's view; the master modport is the view of whatever sits on the
// other side of all three streams.
interface hit_record_join_if #(
  parameter int SIZE = 32,
  parameter int ID_W = 16
);

  // Hit point {z,y,x} plus flags qualified by the hit-point valid
  logic [3*SIZE-1:0] hit_point_axis_tdata;
  logic              hit_point_axis_tvalid;
  logic              hit_point_axis_tready;
  logic              invalid_cylinder_hit;
  logic              red;

  // Unnormalised normal {z,y,x}
  logic [3*SIZE-1:0] normal_axis_tdata;
  logic              normal_axis_tvalid;
  logic              normal_axis_tready;

  // Joined record {red, invalid, normal, hit_point} tagged with the ray index
  logic [6*SIZE+1:0] rec_axis_tdata;
  logic [ID_W-1:0]   rec_axis_tuser;
  logic              rec_axis_tvalid;
  logic              rec_axis_tready;

  modport master (
    output hit_point_axis_tdata,
    output hit_point_axis_tvalid,
    output invalid_cylinder_hit,
    output red,
    output normal_axis_tdata,
    output normal_axis_tvalid,
    output rec_axis_tready,
    input  hit_point_axis_tready,
    input  normal_axis_tready,
    input  rec_axis_tdata,
    input  rec_axis_tuser,
    input  rec_axis_tvalid
  );

  modport slave (
    input  hit_point_axis_tdata,
    input  hit_point_axis_tvalid,
    input  invalid_cylinder_hit,
    input  red,
    input  normal_axis_tdata,
    input  normal_axis_tvalid,
    input  rec_axis_tready,
    output hit_point_axis_tready,
    output normal_axis_tready,
    output rec_axis_tdata,
    output rec_axis_tuser,
    output rec_axis_tvalid
  );

endinterface

// File: rtl/hit_record_join.sv
// hit_record_join: re-aligns the independent hit-point and normal streams
// coming out of the hit-point/normal stage into one record per ray. Each
// stream lands in its own holding register; when both are occupied the pair
// is joined, stamped with a wrapping ray index and pushed into a
// first-word-fall-through record FIFO (or discarded when DROP_INVALID is set
// and the hit is flagged invalid; a dropped ray still consumes its index).
//
// Optional build macro HIT_RECORD_JOIN_STATS_EN adds stat_joined,
// stat_dropped (both saturating 32-bit counters) and stat_max_occ (peak FIFO
// occupancy). Without it those ports and registers do not exist and the
// datapath is unchanged.
module hit_record_join #(
  parameter int SIZE         = 32,
  parameter int DEPTH        = 4,
  parameter int ID_W         = 16,
  parameter int DROP_INVALID = 0
) (
  input  logic                   aclk,
  input  logic                   areset,
  hit_record_join_if.slave       axis
`ifdef HIT_RECORD_JOIN_STATS_EN
  ,
  output logic [31:0]            stat_joined,
  output logic [31:0]            stat_dropped,
  output logic [$clog2(DEPTH):0] stat_max_occ
`endif
);

  localparam int VEC_W = 3 * SIZE;
  localparam int REC_W = 6 * SIZE + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [ID_W-1:0]  IDX_ONE  = ID_W'(1);

`ifdef HIT_RECORD_JOIN_STATS_EN
  // Saturating increment for the 32-bit statistics counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  // Holding registers: one slot per upstream stream, each with a full bit
  logic             hp_full_p0;
  logic             n_full_p0;
  logic [VEC_W-1:0] hp_data_p0;
  logic             hp_inv_p0;
  logic             hp_red_p0;
  logic [VEC_W-1:0] n_data_p0;

  // Record FIFO storage and control
  logic [REC_W-1:0] rec_mem [DEPTH];
  logic [ID_W-1:0]  tag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [ID_W-1:0]  ray_idx;

  // Handshake / join decisions
  logic rec_vld;
  logic fifo_full;
  logic pop;
  logic drop;
  logic join_fire;
  logic push;
  logic hp_ready;
  logic n_ready;
  logic hp_load;
  logic n_load;

  // Join decision: a joined pair can always leave the holding registers when
  // it is being dropped, when the FIFO has room, or when the FIFO is full but
  // the head is leaving on this same edge.
  always_comb begin
    rec_vld   = (count != '0);
    fifo_full = (count == FULL_CNT);
    pop       = rec_vld && axis.rec_axis_tready;
    drop      = (DROP_INVALID != 0) && hp_inv_p0;
    join_fire = hp_full_p0 && n_full_p0 && (drop || !fifo_full || pop);
    push      = join_fire && !drop;
    hp_ready  = !hp_full_p0 || join_fire;
    n_ready   = !n_full_p0 || join_fire;
    hp_load   = axis.hit_point_axis_tvalid && hp_ready;
    n_load    = axis.normal_axis_tvalid && n_ready;
  end

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (!push && pop) begin
      count_nxt = count - CNT_ONE;
    end
  end

  assign axis.hit_point_axis_tready = hp_ready;
  assign axis.normal_axis_tready    = n_ready;

  // Head of the FIFO drives the output directly; zeros while empty
  assign axis.rec_axis_tvalid = rec_vld;
  assign axis.rec_axis_tdata  = rec_vld ? rec_mem[rd_ptr] : '0;
  assign axis.rec_axis_tuser  = rec_vld ? tag_mem[rd_ptr] : '0;

  // ---- stage p0: upstream handshake into the holding registers ----

  // Holding register occupancy: set on load, cleared on join (load wins so a
  // new beat can refill the slot on the same edge it is joined)
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hp_full_p0 <= 1'b0;
      n_full_p0  <= 1'b0;
    end else begin
      if (hp_load) begin
        hp_full_p0 <= 1'b1;
      end else if (join_fire) begin
        hp_full_p0 <= 1'b0;
      end
      if (n_load) begin
        n_full_p0 <= 1'b1;
      end else if (join_fire) begin
        n_full_p0 <= 1'b0;
      end
    end
  end

  // Holding register payloads; sideband is captured only with the hit point
  always_ff @(posedge aclk) begin
    if (hp_load) begin
      hp_data_p0 <= axis.hit_point_axis_tdata;
      hp_inv_p0  <= axis.invalid_cylinder_hit;
      hp_red_p0  <= axis.red;
    end
    if (n_load) begin
      n_data_p0 <= axis.normal_axis_tdata;
    end
  end

  // ---- stage p1: joined record into the FIFO ----

  // FIFO entry write for non-dropped joins
  always_ff @(posedge aclk) begin
    if (push) begin
      rec_mem[wr_ptr] <= {hp_red_p0, hp_inv_p0, n_data_p0, hp_data_p0};
      tag_mem[wr_ptr] <= ray_idx;
    end
  end

  // FIFO pointers, occupancy and the ray index (every join consumes an index)
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ray_idx <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;
      if (join_fire) begin
        ray_idx <= ray_idx + IDX_ONE;
      end
    end
  end

`ifdef HIT_RECORD_JOIN_STATS_EN
  // Statistics: join/drop counters and peak FIFO occupancy
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      stat_joined  <= '0;
      stat_dropped <= '0;
      stat_max_occ <= '0;
    end else begin
      if (join_fire) begin
        stat_joined <= sat_inc32(stat_joined);
      end
      if (join_fire && drop) begin
        stat_dropped <= sat_inc32(stat_dropped);
      end
      if (count_nxt > stat_max_occ) begin
        stat_max_occ <= count_nxt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hit_record_join.sv
// tb_hit_record_join: randomized and directed stimulus for hit_record_join
// (SIZE=8, DEPTH=4, ID_W=3, DROP_INVALID=1), checked against a queue-based
// reference: the k-th hit-point beat pairs with the k-th normal beat, the
// pair gets tag k mod 2^ID_W, invalid pairs vanish, survivors come out in
// order. Build with HIT_RECORD_JOIN_STATS_EN to also check the statistics.
module tb_hit_record_join;

  localparam int SIZE  = 8;
  localparam int DEPTH = 4;
  localparam int ID_W  = 3;
  localparam int VEC_W = 3 * SIZE;
  localparam int REC_W = 6 * SIZE + 2;

  logic aclk = 1'b0;
  logic areset;

  always #5 aclk = ~aclk;

  hit_record_join_if #(.SIZE(SIZE), .ID_W(ID_W)) bus ();

`ifdef HIT_RECORD_JOIN_STATS_EN
  logic [31:0]            stat_joined;
  logic [31:0]            stat_dropped;
  logic [$clog2(DEPTH):0] stat_max_occ;
`endif

  hit_record_join #(
    .SIZE(SIZE), .DEPTH(DEPTH), .ID_W(ID_W), .DROP_INVALID(1)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .axis   (bus)
`ifdef HIT_RECORD_JOIN_STATS_EN
    ,
    .stat_joined  (stat_joined),
    .stat_dropped (stat_dropped),
    .stat_max_occ (stat_max_occ)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state
  typedef struct {
    logic [REC_W-1:0] data;
    logic [ID_W-1:0]  tag;
  } exp_t;

  logic [VEC_W+1:0] hp_q [$];
  logic [VEC_W-1:0] n_q [$];
  exp_t             exp_q [$];
  int               ray_k    = 0;
  int               m_joined = 0;
  int               m_dropped = 0;
  int               n_out    = 0;

  // Monitor: observe handshakes just before the edge they complete on
  always @(negedge aclk) begin
    if (areset) begin
      hp_q.delete();
      n_q.delete();
      exp_q.delete();
      ray_k     = 0;
      m_joined  = 0;
      m_dropped = 0;
      n_out     = 0;
    end else begin
      if (bus.hit_point_axis_tvalid && bus.hit_point_axis_tready)
        hp_q.push_back({bus.red, bus.invalid_cylinder_hit, bus.hit_point_axis_tdata});
      if (bus.normal_axis_tvalid && bus.normal_axis_tready)
        n_q.push_back(bus.normal_axis_tdata);
      if (bus.rec_axis_tvalid && bus.rec_axis_tready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("rec_unexpected", 64'(bus.rec_axis_tvalid), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rec_tdata", 64'(bus.rec_axis_tdata), 64'(e.data));
          check("rec_tuser", 64'(bus.rec_axis_tuser), 64'(e.tag));
        end
      end
      while (hp_q.size() != 0 && n_q.size() != 0) begin
        logic [VEC_W+1:0] h;
        logic [VEC_W-1:0] nv;
        exp_t e;
        h  = hp_q.pop_front();
        nv = n_q.pop_front();
        m_joined++;
        if (h[VEC_W]) begin
          m_dropped++;
        end else begin
          e.data = {h[VEC_W+1], h[VEC_W], nv, h[VEC_W-1:0]};
          e.tag  = ID_W'(ray_k % (1 << ID_W));
          exp_q.push_back(e);
        end
        ray_k++;
      end
    end
  end

  // Driver state
  int hp_todo = 0;
  int n_todo  = 0;
  int hp_sent = 0;
  int p_inv   = 0;
  int inv_ray = -1;

  // One clock: note handshakes, then re-drive after the edge (valid held
  // until accepted; idle cycles carry random garbage on data and flags)
  task automatic tick(input int p_hp, input int p_n, input int p_rdy);
    logic hp_fire;
    logic n_fire;
    @(negedge aclk);
    hp_fire = bus.hit_point_axis_tvalid && bus.hit_point_axis_tready;
    n_fire  = bus.normal_axis_tvalid && bus.normal_axis_tready;
    @(posedge aclk);
    #1;
    if (hp_fire) begin
      hp_todo--;
      hp_sent++;
    end
    if (n_fire) n_todo--;
    if (hp_fire || !bus.hit_point_axis_tvalid) begin
      bus.hit_point_axis_tvalid = (hp_todo > 0) && (int'($urandom_range(99)) < p_hp);
      bus.hit_point_axis_tdata  = VEC_W'($urandom);
      bus.invalid_cylinder_hit  = (hp_sent == inv_ray) || (int'($urandom_range(99)) < p_inv);
      bus.red                   = 1'($urandom);
    end
    if (n_fire || !bus.normal_axis_tvalid) begin
      bus.normal_axis_tvalid = (n_todo > 0) && (int'($urandom_range(99)) < p_n);
      bus.normal_axis_tdata  = VEC_W'($urandom);
    end
    bus.rec_axis_tready = (int'($urandom_range(99)) < p_rdy);
  endtask

  task automatic do_reset();
    bus.hit_point_axis_tvalid = 1'b0;
    bus.normal_axis_tvalid    = 1'b0;
    bus.rec_axis_tready       = 1'b0;
    hp_todo = 0;
    n_todo  = 0;
    hp_sent = 0;
    areset  = 1'b1;
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  // Finish outstanding rays and empty the FIFO, bounded
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((hp_todo > 0 || n_todo > 0 || exp_q.size() != 0 || bus.rec_axis_tvalid) && guard < 400) begin
      tick(100, 100, 100);
      guard++;
    end
    check(tag, 64'(guard < 400), 64'd1);
  endtask

  initial begin
    areset = 1'b1;
    bus.hit_point_axis_tvalid = 1'b0;
    bus.hit_point_axis_tdata  = '0;
    bus.invalid_cylinder_hit  = 1'b0;
    bus.red                   = 1'b0;
    bus.normal_axis_tvalid    = 1'b0;
    bus.normal_axis_tdata     = '0;
    bus.rec_axis_tready       = 1'b0;
    do_reset();
    #1;
    check("reset_tvalid", 64'(bus.rec_axis_tvalid), 64'd0);
    check("reset_hp_tready", 64'(bus.hit_point_axis_tready), 64'd1);
    check("reset_n_tready", 64'(bus.normal_axis_tready), 64'd1);
    check("reset_tdata", 64'(bus.rec_axis_tdata), 64'd0);
    check("reset_tuser", 64'(bus.rec_axis_tuser), 64'd0);

    // Latency: HP at cycle 0, N at cycle 5, record valid at cycle 7
    hp_todo = 1;
    tick(100, 100, 0);
    #1;
    check("lat_hp_tready_c0", 64'(bus.hit_point_axis_tready), 64'd1);
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) n_todo = 1;
      tick(100, 100, 0);
      #1;
      check("lat_hp_tready_blocked", 64'(bus.hit_point_axis_tready), 64'd0);
    end
    tick(100, 100, 0);
    #1;
    check("lat_c6_hp_tready", 64'(bus.hit_point_axis_tready), 64'd1);
    check("lat_c6_n_tready", 64'(bus.normal_axis_tready), 64'd1);
    check("lat_c6_tvalid", 64'(bus.rec_axis_tvalid), 64'd0);
    tick(100, 100, 0);
    #1;
    check("lat_c7_tvalid", 64'(bus.rec_axis_tvalid), 64'd1);
    check("lat_c7_tuser", 64'(bus.rec_axis_tuser), 64'd0);
    drain("lat_drain_timeout");

    // Backpressure: 6 rays into a DEPTH=4 FIFO with output stalled
    do_reset();
    hp_todo = 6;
    n_todo  = 6;
    repeat (10) tick(100, 100, 0);
    #1;
    check("full_hp_tready", 64'(bus.hit_point_axis_tready), 64'd0);
    check("full_n_tready", 64'(bus.normal_axis_tready), 64'd0);
    check("full_tvalid", 64'(bus.rec_axis_tvalid), 64'd1);
    check("full_head_tuser", 64'(bus.rec_axis_tuser), 64'd0);
    // one-cycle release: pop and push on the same edge
    tick(100, 100, 100);
    #1;
    check("full_pop_hp_tready", 64'(bus.hit_point_axis_tready), 64'd1);
    tick(100, 100, 0);
    #1;
    check("full_after_tvalid", 64'(bus.rec_axis_tvalid), 64'd1);
    check("full_after_tuser", 64'(bus.rec_axis_tuser), 64'd1);
    check("full_after_hp_tready", 64'(bus.hit_point_axis_tready), 64'd0);
`ifdef HIT_RECORD_JOIN_STATS_EN
    check("stat_max_occ_full", 64'(stat_max_occ), 64'd4);
`endif
    drain("full_drain_timeout");
    check("full_out_count", 64'(n_out), 64'd6);

    // Drop: rays 0..3 with ray 2 invalid -> tuser 0,1,3
    do_reset();
    inv_ray = 2;
    hp_todo = 4;
    n_todo  = 4;
    drain("drop_drain_timeout");
    check("drop_out_count", 64'(n_out), 64'd3);
`ifdef HIT_RECORD_JOIN_STATS_EN
    check("stat_joined_drop", 64'(stat_joined), 64'd4);
    check("stat_dropped_drop", 64'(stat_dropped), 64'd1);
`endif
    inv_ray = -1;

    // Mid-operation reset with 3 records buffered and an HP held
    do_reset();
    hp_todo = 4;
    n_todo  = 3;
    repeat (8) tick(100, 100, 0);
    #1;
    check("rst_pre_tvalid", 64'(bus.rec_axis_tvalid), 64'd1);
    check("rst_pre_hp_tready", 64'(bus.hit_point_axis_tready), 64'd0);
    bus.hit_point_axis_tvalid = 1'b0;
    hp_todo = 0;
    areset  = 1'b1;
    #1;
    check("rst_tvalid", 64'(bus.rec_axis_tvalid), 64'd0);
    check("rst_hp_tready", 64'(bus.hit_point_axis_tready), 64'd1);
    check("rst_n_tready", 64'(bus.normal_axis_tready), 64'd1);
    check("rst_tuser", 64'(bus.rec_axis_tuser), 64'd0);
    @(posedge aclk);
    #1;
    areset  = 1'b0;
    hp_sent = 0;
    hp_todo = 1;
    n_todo  = 1;
    tick(100, 100, 0);
    tick(100, 100, 0);
    tick(100, 100, 0);
    #1;
    check("rst_next_tvalid", 64'(bus.rec_axis_tvalid), 64'd1);
    check("rst_next_tuser", 64'(bus.rec_axis_tuser), 64'd0);
    drain("rst_drain_timeout");

    // Random traffic: independent valids, bursty backpressure, invalid hits
    do_reset();
    p_inv   = 25;
    hp_todo = 150;
    n_todo  = 150;
    begin
      int guard;
      guard = 0;
      while ((hp_todo > 0 || n_todo > 0) && guard < 3000) begin
        tick(60, 55, ((guard / 40) % 2 == 1) ? 90 : 25);
        guard++;
      end
      check("rand_timeout", 64'(guard < 3000), 64'd1);
    end
    drain("rand_drain_timeout");
    check("rand_exp_empty", 64'(exp_q.size()), 64'd0);
    check("rand_joined", 64'(m_joined), 64'd150);
`ifdef HIT_RECORD_JOIN_STATS_EN
    check("stat_joined_rand", 64'(stat_joined), 64'(m_joined));
    check("stat_dropped_rand", 64'(stat_dropped), 64'(m_dropped));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
